revelador_papeis: RTL and testbench
===================================

Name: revelador_papeis

Overview:
- Consumes the 10-bit game word `jogo_atual` (bit i = 1: player i is lobinho; bit i = 0: aldeão) after the seed/game-generation path has produced it.
- Hands the device from player to player: each player in turn reveals their role privately, then hides it and passes the device on.
- Sits beside the game generator in the data path. It is driven by debounced button levels and provides role/display outputs plus a done flag to the game controller.

Parameters:
- N_JOGADORES, 10, number of players; legal range 2..10; sets the highest index stepped through and which bits of `jogo_atual` are used.
- TEMPO_MOSTRA, 5000, clock cycles a role stays visible before auto-hide; minimum 2.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- iniciar  in  1  level; rising edge starts a reveal round.
- botao  in  1  level; rising edge reveals the current player's role.
- passa  in  1  level; rising edge hides the role and advances to the next player.
- jogo_atual  in  10  role vector; sampled only on the start edge.
- jogador_atual  out  4  index of the player holding the device (0..N_JOGADORES-1).
- papel_visivel  out  1  1 while the role is shown.
- papel  out  1  role of the current player (1 = lobinho); forced to 0 whenever `papel_visivel` = 0.
- fim  out  1  high once every player has seen their role; held until the next start.
- db_estado  out  4  current state encoding.

Behaviour:
- Reset (asynchronous, active-high): state OCIOSO, `jogador_atual` = 0, `papel_visivel` = 0, `papel` = 0, `fim` = 0, latched game word = 0, timer = 0, edge-detect registers = 0.
- Edge detect:
  - Each of `iniciar`, `botao` and `passa` has a previous-value register.
  - A rising edge is current AND NOT previous, giving a one-cycle pulse.
  - A level held high produces exactly one pulse.
- State encodings: OCIOSO = 0, CARREGA = 1, ESPERA = 2, MOSTRA = 3, ESCONDE = 4, FIM = 5.
- OCIOSO: on an `iniciar` edge, go to CARREGA.
- CARREGA (1 cycle):
  - Latch `jogo_atual`, set `jogador_atual` = 0, clear `fim`.
  - Go to ESPERA.
- ESPERA: on a `botao` edge, go to MOSTRA, clear the timer, set `papel_visivel` = 1.
- MOSTRA:
  - `papel` = latched bit [`jogador_atual`].
  - The timer increments every cycle.
  - Exit on a `passa` edge, or when the timer reaches TEMPO_MOSTRA-1; either exit goes to ESCONDE.
  - A `botao` edge while in MOSTRA is ignored.
- ESCONDE (1 cycle):
  - `papel_visivel` = 0, `papel` = 0.
  - If `jogador_atual` = N_JOGADORES-1, go to FIM.
  - Otherwise increment `jogador_atual` and go to ESPERA.
- Auto-hide path: after a timeout, the same player does NOT advance.
  - The transition taken is ESCONDE → ESPERA with an unchanged index.
  - Advance happens only through a `passa` edge.
  - To make this work, ESCONDE increments only when it was entered by `passa`. A one-bit flag `via_passa` is registered on MOSTRA exit.
  - A timeout exit returns to ESPERA so the same player may reveal again.
- `passa` edge in ESPERA:
  - Advances with no reveal, i.e. the player skips viewing.
  - Increment, or go to FIM if the player is the last one.
- FIM:
  - `fim` = 1, `jogador_atual` holds N_JOGADORES-1, `papel_visivel` = 0.
  - An `iniciar` edge goes to CARREGA (a new round).
- Simultaneous events:
  - `botao` and `passa` edges in the same cycle in ESPERA: `passa` wins (advance, no reveal).
  - `passa` edge and timeout in the same MOSTRA cycle: treated as `passa` (advance).
  - `iniciar` edges are ignored in every state except OCIOSO and FIM.
- `jogo_atual` changes after CARREGA have no effect until the next start.
- Bits of `jogo_atual` at index ≥ N_JOGADORES are never displayed.
- Reset mid-round: immediate return to the reset values. `papel` goes to 0 asynchronously, so no role remains visible.
- Outputs are registered or state-decoded with no combinational path from the inputs. `papel` is valid in the cycle after MOSTRA entry, the same cycle `papel_visivel` rises.

Test Plan:
- Reset, then `iniciar` edge with `jogo_atual` = 10'b0000100010 → `db_estado` goes 0→1→2; `jogador_atual` = 0; `fim` = 0; `papel_visivel` = 0.
- Per player: `botao` edge then `passa` edge, looped for players 0..9 → `papel` = 1 only for players 1 and 5. `papel_visivel` pulses 10 times. After the 10th `passa`, `fim` = 1 and `jogador_atual` = 9.
- Timeout with TEMPO_MOSTRA = 8: `botao` edge, no `passa` → `papel_visivel` drops after 8 cycles; `jogador_atual` stays at 0; state returns to 2.
- Simultaneous `botao` and `passa` edges in ESPERA at player 3 → no reveal; `jogador_atual` = 4. `botao` held high for 20 cycles in ESPERA → exactly one reveal.
- Reset asserted during MOSTRA with `papel` = 1 → `papel` = 0, `papel_visivel` = 0, `db_estado` = 0 immediately, before the next clock edge.
- In FIM, change `jogo_atual` to 10'h3FF, then an `iniciar` edge → `fim` clears and every player reveals `papel` = 1. With N_JOGADORES = 3, `fim` is set after 3 `passa` edges.

Source files
------------

// File: rtl/revelador_papeis.sv
// Role reveal sequencer: walks the device through every player, letting each one
// privately view (or skip) their lobinho/aldeao role before passing it on.
module revelador_papeis #(
  parameter int N_JOGADORES  = 10,
  parameter int TEMPO_MOSTRA = 5000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic       botao,
  input  logic       passa,
  input  logic [9:0] jogo_atual,
  output logic [3:0] jogador_atual,
  output logic       papel_visivel,
  output logic       papel,
  output logic       fim,
  output logic [3:0] db_estado
);

  typedef enum logic [3:0] {
    OCIOSO  = 4'd0,
    CARREGA = 4'd1,
    ESPERA  = 4'd2,
    MOSTRA  = 4'd3,
    ESCONDE = 4'd4,
    FIM     = 4'd5
  } estado_t;

  localparam int              TW        = (TEMPO_MOSTRA > 2) ? $clog2(TEMPO_MOSTRA) : 1;
  localparam logic [TW-1:0]   TIMER_MAX = TW'(TEMPO_MOSTRA - 1);
  localparam logic [3:0]      ULTIMO    = 4'(N_JOGADORES - 1);
  localparam logic [9:0]      MASCARA   = 10'((1 << N_JOGADORES) - 1);

  estado_t       estado_q, estado_d;
  logic [3:0]    jogador_q, jogador_d;
  logic          visivel_q, visivel_d;
  logic          papel_q, papel_d;
  logic          fim_q, fim_d;
  logic [9:0]    jogo_q, jogo_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          via_passa_q, via_passa_d;
  logic          iniciar_prev_q, iniciar_prev_d;
  logic          botao_prev_q, botao_prev_d;
  logic          passa_prev_q, passa_prev_d;

  logic iniciar_pulso, botao_pulso, passa_pulso;

  assign iniciar_pulso = iniciar & ~iniciar_prev_q;
  assign botao_pulso   = botao   & ~botao_prev_q;
  assign passa_pulso   = passa   & ~passa_prev_q;

  always_comb begin
    // NOTE: every signal written here gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    estado_d       = estado_q;
    jogador_d      = jogador_q;
    visivel_d      = visivel_q;
    papel_d        = papel_q;
    fim_d          = fim_q;
    jogo_d         = jogo_q;
    timer_d        = timer_q;
    via_passa_d    = via_passa_q;
    iniciar_prev_d = iniciar;
    botao_prev_d   = botao;
    passa_prev_d   = passa;

    case (estado_q)
      OCIOSO: begin
        if (iniciar_pulso) estado_d = CARREGA;
      end
      CARREGA: begin
        jogo_d    = jogo_atual & MASCARA;
        jogador_d = 4'd0;
        fim_d     = 1'b0;
        estado_d  = ESPERA;
      end
      ESPERA: begin
        // A pass edge beats a simultaneous reveal: the player skips viewing.
        if (passa_pulso) begin
          if (jogador_q == ULTIMO) begin
            estado_d = FIM;
            fim_d    = 1'b1;
          end else begin
            jogador_d = jogador_q + 4'd1;
          end
        end else if (botao_pulso) begin
          estado_d  = MOSTRA;
          timer_d   = '0;
          visivel_d = 1'b1;
          papel_d   = jogo_q[jogador_q];
        end
      end
      MOSTRA: begin
        timer_d = timer_q + 1'b1;
        if (passa_pulso || (timer_q == TIMER_MAX)) begin
          estado_d    = ESCONDE;
          via_passa_d = passa_pulso;
          visivel_d   = 1'b0;
          papel_d     = 1'b0;
        end
      end
      ESCONDE: begin
        visivel_d = 1'b0;
        papel_d   = 1'b0;
        estado_d  = ESPERA;
        // A timeout hides the role but keeps the same player holding the device.
        if (via_passa_q) begin
          if (jogador_q == ULTIMO) begin
            estado_d = FIM;
            fim_d    = 1'b1;
          end else begin
            jogador_d = jogador_q + 4'd1;
          end
        end
      end
      FIM: begin
        visivel_d = 1'b0;
        papel_d   = 1'b0;
        fim_d     = 1'b1;
        if (iniciar_pulso) estado_d = CARREGA;
      end
      default: estado_d = OCIOSO;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // its _d value from the same pre-edge snapshot.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado_q       <= OCIOSO;
      jogador_q      <= 4'd0;
      visivel_q      <= 1'b0;
      papel_q        <= 1'b0;
      fim_q          <= 1'b0;
      jogo_q         <= 10'd0;
      timer_q        <= '0;
      via_passa_q    <= 1'b0;
      iniciar_prev_q <= 1'b0;
      botao_prev_q   <= 1'b0;
      passa_prev_q   <= 1'b0;
    end else begin
      estado_q       <= estado_d;
      jogador_q      <= jogador_d;
      visivel_q      <= visivel_d;
      papel_q        <= papel_d;
      fim_q          <= fim_d;
      jogo_q         <= jogo_d;
      timer_q        <= timer_d;
      via_passa_q    <= via_passa_d;
      iniciar_prev_q <= iniciar_prev_d;
      botao_prev_q   <= botao_prev_d;
      passa_prev_q   <= passa_prev_d;
    end
  end

  assign jogador_atual = jogador_q;
  assign papel_visivel = visivel_q;
  assign papel         = papel_q;
  assign fim           = fim_q;
  assign db_estado     = estado_q;

endmodule

// File: tb/tb_revelador_papeis.sv
// Bench for revelador_papeis: fixed and randomized reveal rounds checked against an
// action-level player/role model, plus timeout, edge, reset and 3-player cases.
module tb_revelador_papeis;

  localparam int T = 8;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       iniciar = 1'b0, botao = 1'b0, passa = 1'b0;
  logic [9:0] jogo_atual = 10'd0;
  logic [3:0] jogador_atual, db_estado;
  logic       papel_visivel, papel, fim;

  logic       ini3 = 1'b0, bot3 = 1'b0, pas3 = 1'b0;
  logic [9:0] jogo3 = 10'd0;
  logic [3:0] jogador3, estado3;
  logic       vis3, papel3, fim3;

  int n_pass = 0;
  int n_total = 0;

  logic [9:0]  m_word;
  logic [10:0] obs, exp;

  always #5 clock = ~clock;

  revelador_papeis #(.N_JOGADORES(10), .TEMPO_MOSTRA(T)) dut (
    .clock(clock), .reset(reset), .iniciar(iniciar), .botao(botao), .passa(passa),
    .jogo_atual(jogo_atual), .jogador_atual(jogador_atual), .papel_visivel(papel_visivel),
    .papel(papel), .fim(fim), .db_estado(db_estado)
  );

  revelador_papeis #(.N_JOGADORES(3), .TEMPO_MOSTRA(T)) dut3 (
    .clock(clock), .reset(reset), .iniciar(ini3), .botao(bot3), .passa(pas3),
    .jogo_atual(jogo3), .jogador_atual(jogador3), .papel_visivel(vis3),
    .papel(papel3), .fim(fim3), .db_estado(estado3)
  );

  function automatic logic [10:0] mk(input int s, input int p, input logic v, input logic r,
                                     input logic f);
    return {4'(s), 4'(p), v, r, f};
  endfunction

  function automatic logic [10:0] st();
    return {db_estado, jogador_atual, papel_visivel, papel, fim};
  endfunction

  function automatic logic [10:0] st3();
    return {estado3, jogador3, vis3, papel3, fim3};
  endfunction

  task automatic press(input logic i, input logic b, input logic p);
    @(negedge clock);
    iniciar = i; botao = b; passa = p;
    @(negedge clock);
    iniciar = 1'b0; botao = 1'b0; passa = 1'b0;
  endtask

  task automatic press3(input logic i, input logic b, input logic p);
    @(negedge clock);
    ini3 = i; bot3 = b; pas3 = p;
    @(negedge clock);
    ini3 = 1'b0; bot3 = 1'b0; pas3 = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clock);
    obs = st(); exp = mk(0, 0, 0, 0, 0);
    n_total++;
    if (obs !== exp) $display("FAIL reset_state: observed %h required %h", obs, exp);
    else n_pass++;
    reset = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_start(input logic [9:0] word);
    jogo_atual = word;
    press(1, 0, 0);
    n_total++;
    if (db_estado !== 4'd1) $display("FAIL start_carrega: observed %0d required 1", db_estado);
    else n_pass++;
    @(negedge clock);
    m_word = word;
    jogo_atual = 10'($urandom);  // must not affect the latched round
    obs = st(); exp = mk(2, 0, 0, 0, 0);
    n_total++;
    if (obs !== exp) $display("FAIL start_espera: observed %h required %h", obs, exp);
    else n_pass++;
  endtask

  // mode 0: every player reveals then passes; mode 1: random reveal/skip/timeout mix
  task automatic play_round(input bit aleatorio);
    int acao;
    int k;
    int ones = 0;
    int exp_ones = 0;
    for (int p = 0; p < 10; p++) begin
      acao = aleatorio ? int'($urandom_range(0, 2)) : 0;
      if (acao != 1) begin
        press(0, 1, 0);
        obs = st(); exp = mk(3, p, 1, m_word[p], 0);
        n_total++;
        if (obs !== exp) $display("FAIL round_reveal p%0d: observed %h required %h", p, obs, exp);
        else n_pass++;
        if (papel === 1'b1) ones++;
        if (m_word[p]) exp_ones++;
        if (acao == 2) begin
          k = 0;
          while (papel_visivel === 1'b1 && k < 4 * T) begin
            @(negedge clock);
            k++;
          end
          @(negedge clock);
          obs = st(); exp = mk(2, p, 0, 0, 0);
          n_total++;
          if (obs !== exp) $display("FAIL round_timeout p%0d: observed %h required %h", p, obs, exp);
          else n_pass++;
        end
      end
      press(0, 0, 1);
      if (acao == 0) @(negedge clock);
      obs = st();
      exp = (p == 9) ? mk(5, 9, 0, 0, 1) : mk(2, p + 1, 0, 0, 0);
      n_total++;
      if (obs !== exp) $display("FAIL round_pass p%0d: observed %h required %h", p, obs, exp);
      else n_pass++;
    end
    n_total++;
    if (ones !== exp_ones) $display("FAIL round_role_count: observed %0d required %0d", ones, exp_ones);
    else n_pass++;
  endtask

  task automatic test_timeout();
    int cnt;
    press(0, 1, 0);
    cnt = 1;
    for (int k = 0; k < 4 * T; k++) begin
      @(negedge clock);
      if (papel_visivel === 1'b1) cnt++;
      else break;
    end
    n_total++;
    if (cnt !== T) $display("FAIL timeout_length: observed %0d required %0d", cnt, T);
    else n_pass++;
    @(negedge clock);
    obs = st(); exp = mk(2, 0, 0, 0, 0);
    n_total++;
    if (obs !== exp) $display("FAIL timeout_same_player: observed %h required %h", obs, exp);
    else n_pass++;
    press(1, 0, 0);
    obs = st();
    n_total++;
    if (obs !== exp) $display("FAIL iniciar_ignored: observed %h required %h", obs, exp);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    int rises;
    logic prev;
    repeat (3) press(0, 0, 1);
    n_total++;
    if (jogador_atual !== 4'd3) $display("FAIL skip_to_3: observed %0d required 3", jogador_atual);
    else n_pass++;
    press(0, 1, 1);
    obs = st(); exp = mk(2, 4, 0, 0, 0);
    n_total++;
    if (obs !== exp) $display("FAIL botao_passa_same_cycle: observed %h required %h", obs, exp);
    else n_pass++;
    @(negedge clock);
    botao = 1'b1;
    rises = 0;
    prev = 1'b0;
    repeat (20) begin
      @(negedge clock);
      if (papel_visivel === 1'b1 && prev === 1'b0) rises++;
      prev = papel_visivel;
    end
    botao = 1'b0;
    n_total++;
    if (rises !== 1) $display("FAIL botao_held_reveals: observed %0d required 1", rises);
    else n_pass++;
    obs = st(); exp = mk(2, 4, 0, 0, 0);
    n_total++;
    if (obs !== exp) $display("FAIL botao_held_state: observed %h required %h", obs, exp);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    press(0, 0, 1);
    press(0, 1, 0);
    obs = st(); exp = mk(3, 5, 1, 1, 0);
    n_total++;
    if (obs !== exp) $display("FAIL pre_reset_show: observed %h required %h", obs, exp);
    else n_pass++;
    #2 reset = 1'b1;
    #1;
    obs = st(); exp = mk(0, 0, 0, 0, 0);
    n_total++;
    if (obs !== exp) $display("FAIL async_reset: observed %h required %h", obs, exp);
    else n_pass++;
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_three_players();
    jogo3 = 10'h3FF;
    press3(1, 0, 0);
    @(negedge clock);
    press3(0, 1, 0);
    obs = st3(); exp = mk(3, 0, 1, 1, 0);
    n_total++;
    if (obs !== exp) $display("FAIL n3_reveal: observed %h required %h", obs, exp);
    else n_pass++;
    press3(0, 0, 1);
    @(negedge clock);
    press3(0, 0, 1);
    obs = st3(); exp = mk(2, 2, 0, 0, 0);
    n_total++;
    if (obs !== exp) $display("FAIL n3_two_passes: observed %h required %h", obs, exp);
    else n_pass++;
    press3(0, 0, 1);
    obs = st3(); exp = mk(5, 2, 0, 0, 1);
    n_total++;
    if (obs !== exp) $display("FAIL n3_fim: observed %h required %h", obs, exp);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_start(10'b0000100010);
    play_round(1'b0);
    test_start(10'h3FF);
    play_round(1'b0);
    repeat (2) begin
      test_start(10'($urandom));
      play_round(1'b1);
    end
    test_start(10'b0000100010);
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    test_three_players();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
